// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
package hazard_pkg;

    // Memory-wait supervisor states
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } hz_state_e;

    // ALU operand forwarding selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Execute result-select value that identifies a load
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Forward select for one Execute source; Memory beats Writeback, x0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs_e
    );
        logic [1:0] sel;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Width-parameterised up counter that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment when enabled unless already saturated
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and memory-wait stalls,
// branch flushes, memory timeout supervision and a stalled-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D_i,
    input  logic [4:0]  Rs2D_i,
    input  logic [4:0]  Rs1E_i,
    input  logic [4:0]  Rs2E_i,
    input  logic [4:0]  RdE_i,
    input  logic [1:0]  ResultSrcE_i,
    input  logic [4:0]  RdM_i,
    input  logic [4:0]  RdW_i,
    input  logic        RegWriteM_i,
    input  logic        RegWriteW_i,
    input  logic        PCSrcE_i,
    input  logic        MemAccessM_i,
    input  logic        MemReadyM_i,
    output logic        StallF_o,
    output logic        StallD_o,
    output logic        StallE_o,
    output logic        StallM_o,
    output logic        FlushD_o,
    output logic        FlushE_o,
    output logic        FlushW_o,
    output logic [1:0]  ForwardAE_o,
    output logic [1:0]  ForwardBE_o,
    output logic        MemTimeout_o,
    output logic [31:0] StallCycles_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    logic             lw_stall_s;
    logic             mem_stall_s;
    logic             stall_f_s;
    logic             stall_d_s;
    logic             stall_e_s;
    logic             stall_m_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic             flush_w_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    // Operand forwarding for both Execute sources
    always_comb begin
        fwd_a_s = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs1E_i);
        fwd_b_s = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs2E_i);
    end

    // Stall sources: load-use in Decode and a pending/failed memory access
    always_comb begin
        lw_stall_s  = (ResultSrcE_i == RESULTSRC_LOAD) && (RdE_i != 5'd0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
        mem_stall_s = (MemAccessM_i && !MemReadyM_i) || (state_q == ERROR);
    end

    // Stall/flush control; a memory stall freezes F..M and bubbles W, and
    // suppresses branch flushes so a held PCSrcE flushes once E moves again
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        if (mem_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else begin
            stall_f_s = lw_stall_s;
            stall_d_s = lw_stall_s;
            flush_d_s = PCSrcE_i;
            flush_e_s = lw_stall_s || PCSrcE_i;
        end
    end

    // Memory-wait supervisor next state; ERROR holds until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (MemAccessM_i && !MemReadyM_i) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                if (MemReadyM_i) begin
                    state_d = RUN;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = ERROR;
                end else begin
                    state_d = WAIT;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Wait counter: cleared on entry to WAIT, counts unready WAIT cycles
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q == RUN) && (state_d == WAIT)) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == WAIT) && !MemReadyM_i) begin
            wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Timeout flag tracks the registered state so it is high exactly in ERROR
    always_comb begin
        timeout_d = (state_d == ERROR);
    end

    // Supervisor state, wait counter and timeout flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= {CNT_W{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (stall_f_s),
        .count_o (StallCycles_o)
    );

    assign StallF_o     = stall_f_s;
    assign StallD_o     = stall_d_s;
    assign StallE_o     = stall_e_s;
    assign StallM_o     = stall_m_s;
    assign FlushD_o     = flush_d_s;
    assign FlushE_o     = flush_e_s;
    assign FlushW_o     = flush_w_s;
    assign ForwardAE_o  = fwd_a_s;
    assign ForwardBE_o  = fwd_b_s;
    assign MemTimeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (TIMEOUT_CYCLES = 8).
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
    logic [1:0]  ResultSrcE_i;
    logic        RegWriteM_i, RegWriteW_i, PCSrcE_i, MemAccessM_i, MemReadyM_i;
    logic        StallF_o, StallD_o, StallE_o, StallM_o;
    logic        FlushD_o, FlushE_o, FlushW_o;
    logic [1:0]  ForwardAE_o, ForwardBE_o;
    logic        MemTimeout_o;
    logic [31:0] StallCycles_o;

    int n_asserts = 0;
    int n_fail    = 0;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] CTL_IDLE   = 7'b0000000;
    localparam logic [6:0] CTL_LOADU  = 7'b1100010;
    localparam logic [6:0] CTL_BRANCH = 7'b0000110;
    localparam logic [6:0] CTL_MEM    = 7'b1111001;

    hazard_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .Rs1D_i        (Rs1D_i),
        .Rs2D_i        (Rs2D_i),
        .Rs1E_i        (Rs1E_i),
        .Rs2E_i        (Rs2E_i),
        .RdE_i         (RdE_i),
        .ResultSrcE_i  (ResultSrcE_i),
        .RdM_i         (RdM_i),
        .RdW_i         (RdW_i),
        .RegWriteM_i   (RegWriteM_i),
        .RegWriteW_i   (RegWriteW_i),
        .PCSrcE_i      (PCSrcE_i),
        .MemAccessM_i  (MemAccessM_i),
        .MemReadyM_i   (MemReadyM_i),
        .StallF_o      (StallF_o),
        .StallD_o      (StallD_o),
        .StallE_o      (StallE_o),
        .StallM_o      (StallM_o),
        .FlushD_o      (FlushD_o),
        .FlushE_o      (FlushE_o),
        .FlushW_o      (FlushW_o),
        .ForwardAE_o   (ForwardAE_o),
        .ForwardBE_o   (ForwardBE_o),
        .MemTimeout_o  (MemTimeout_o),
        .StallCycles_o (StallCycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o},
            {25'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        Rs1D_i = 5'd0; Rs2D_i = 5'd0; Rs1E_i = 5'd0; Rs2E_i = 5'd0;
        RdE_i = 5'd0; RdM_i = 5'd0; RdW_i = 5'd0; ResultSrcE_i = 2'b00;
        RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; PCSrcE_i = 1'b0;
        MemAccessM_i = 1'b0; MemReadyM_i = 1'b1;

        // Reset state
        #3;
        chk("rst_timeout", {31'd0, MemTimeout_o}, 32'd0);
        chk("rst_stallcnt", StallCycles_o, 32'd0);
        chk_ctl("rst_ctl", CTL_IDLE);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_stallcnt", StallCycles_o, 32'd0);

        // Forwarding: Memory wins over Writeback
        RdM_i = 5'd5; RdW_i = 5'd5; Rs1E_i = 5'd5;
        RegWriteM_i = 1'b1; RegWriteW_i = 1'b1;
        #1;
        chk("fwdA_mem", {30'd0, ForwardAE_o}, 32'd2);
        chk("fwdB_none", {30'd0, ForwardBE_o}, 32'd0);
        // Destination x0 in Memory never forwards
        RdM_i = 5'd0;
        #1;
        chk("fwdA_wb", {30'd0, ForwardAE_o}, 32'd1);
        RegWriteW_i = 1'b0;
        #1;
        chk("fwdA_rf", {30'd0, ForwardAE_o}, 32'd0);
        // Source B from Writeback when Memory does not write
        Rs2E_i = 5'd7; RdW_i = 5'd7; RdM_i = 5'd7; RegWriteM_i = 1'b0; RegWriteW_i = 1'b1;
        #1;
        chk("fwdB_wb", {30'd0, ForwardBE_o}, 32'd1);
        RegWriteM_i = 1'b1;
        #1;
        chk("fwdB_mem", {30'd0, ForwardBE_o}, 32'd2);
        RdM_i = 5'd0; RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; RdW_i = 5'd0;
        Rs1E_i = 5'd0; Rs2E_i = 5'd0;

        // Load destination x0 and non-load results do not stall
        ResultSrcE_i = 2'b01; RdE_i = 5'd0; Rs1D_i = 5'd0;
        #1;
        chk_ctl("lw_x0_nostall", CTL_IDLE);
        ResultSrcE_i = 2'b10; RdE_i = 5'd3; Rs2D_i = 5'd3;
        #1;
        chk_ctl("nonload_nostall", CTL_IDLE);

        // Load-use: one stall cycle
        ResultSrcE_i = 2'b01;
        #1;
        chk_ctl("loaduse_ctl", CTL_LOADU);
        step();
        chk("loaduse_cnt", StallCycles_o, 32'd1);
        ResultSrcE_i = 2'b00; RdE_i = 5'd0; Rs2D_i = 5'd0;
        #1;
        chk_ctl("loaduse_done", CTL_IDLE);

        // Branch alone flushes D and E
        PCSrcE_i = 1'b1;
        #1;
        chk_ctl("branch_ctl", CTL_BRANCH);
        step();
        PCSrcE_i = 1'b0;
        chk("branch_cnt", StallCycles_o, 32'd1);

        // Memory wait of 4 cycles
        MemAccessM_i = 1'b1; MemReadyM_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk_ctl("memwait_ctl", CTL_MEM);
            step();
            chk("memwait_cnt", StallCycles_o, 32'(1 + i));
        end
        MemReadyM_i = 1'b1;
        #1;
        chk_ctl("memwait_release", CTL_IDLE);
        step();
        chk("memwait_final_cnt", StallCycles_o, 32'd5);
        MemAccessM_i = 1'b0;
        #1;
        chk_ctl("memwait_run", CTL_IDLE);

        // Branch held through a 3-cycle wait flushes in the release cycle
        PCSrcE_i = 1'b1; MemAccessM_i = 1'b1; MemReadyM_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk_ctl("brwait_ctl", CTL_MEM);
            step();
        end
        MemReadyM_i = 1'b1;
        #1;
        chk_ctl("brwait_release", CTL_BRANCH);
        chk("brwait_cnt", StallCycles_o, 32'd8);
        step();
        PCSrcE_i = 1'b0; MemAccessM_i = 1'b0;
        #1;
        chk_ctl("brwait_idle", CTL_IDLE);

        // Timeout: 8 WAIT cycles without ready
        MemAccessM_i = 1'b1; MemReadyM_i = 1'b0;
        #1;
        chk_ctl("to_start_ctl", CTL_MEM);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("to_not_yet", {31'd0, MemTimeout_o}, 32'd0);
        end
        step();
        chk("to_raised", {31'd0, MemTimeout_o}, 32'd1);
        chk_ctl("to_ctl", CTL_MEM);
        MemAccessM_i = 1'b0; MemReadyM_i = 1'b1;
        #1;
        chk_ctl("to_sticky_ctl", CTL_MEM);
        step();
        chk("to_sticky", {31'd0, MemTimeout_o}, 32'd1);

        // Asynchronous reset clears the error immediately
        rst = 1'b1;
        #1;
        chk("async_rst_timeout", {31'd0, MemTimeout_o}, 32'd0);
        chk("async_rst_cnt", StallCycles_o, 32'd0);
        chk_ctl("async_rst_ctl", CTL_IDLE);
        step();
        rst = 1'b0;
        step();
        chk_ctl("after_rst_ctl", CTL_IDLE);
        chk("after_rst_timeout", {31'd0, MemTimeout_o}, 32'd0);
        chk("after_rst_cnt", StallCycles_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, is the number of consecutive memory-wait cycles before a timeout error is declared.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 Rs1D_i, Rs2D_i  input  5 each  source registers of the instruction in Decode.
REQ-005 Rs1E_i, Rs2E_i, RdE_i  input  5 each  sources and destination of the instruction in Execute.
REQ-006 ResultSrcE_i  input  2  Execute result select; 2'b01 marks a load.
REQ-007 RdM_i, RdW_i  input  5 each  destinations in Memory and Writeback.
REQ-008 RegWriteM_i, RegWriteW_i  input  1 each  register-write enables in Memory and Writeback.
REQ-009 PCSrcE_i  input  1  taken branch or jump resolved in Execute.
REQ-010 MemAccessM_i, MemReadyM_i  input  1 each  Memory-stage load/store request; data memory ready.
REQ-011 StallF_o, StallD_o, StallE_o, StallM_o  output  1 each  hold the PC and the F/D, D/E and E/M registers.
REQ-012 FlushD_o, FlushE_o, FlushW_o  output  1 each  synchronous clear for the F/D, D/E and M/W registers (drive their CLR).
REQ-013 ForwardAE_o, ForwardBE_o  output  2 each  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-014 MemTimeout_o  output  1  sticky memory-timeout error.
REQ-015 StallCycles_o  output  32  performance count of stalled cycles.

Function
REQ-016 ForwardAE_o SHALL be 10 if RegWriteM_i and RdM_i!=0 and RdM_i==Rs1E_i; else 01 if RegWriteW_i and RdW_i!=0 and RdW_i==Rs1E_i; else 00. ForwardBE_o SHALL use the same rule with Rs2E_i. Memory takes priority; both outputs are combinational.
REQ-017 lwStall SHALL be ResultSrcE_i==01 and RdE_i!=0 and RdE_i equals Rs1D_i or Rs2D_i.
REQ-018 memStall SHALL be (MemAccessM_i and not MemReadyM_i) or state==ERROR; it is combinational, so a stall begins in the same cycle the memory is not ready.
REQ-019 memStall SHALL assert StallF_o, StallD_o, StallE_o, StallM_o and FlushW_o, and SHALL force FlushD_o and FlushE_o to 0.
REQ-020 Without memStall: StallF_o=StallD_o=lwStall; StallE_o=StallM_o=FlushW_o=0; FlushD_o=PCSrcE_i; FlushE_o=lwStall or PCSrcE_i.
REQ-021 A PCSrcE_i held during memStall SHALL produce its flush in the first cycle after memStall deasserts, because E is frozen and PCSrcE_i persists.
REQ-022 FSM states are RUN, WAIT and ERROR.
- RUN->WAIT when MemAccessM_i and not MemReadyM_i.
- WAIT->RUN when MemReadyM_i.
- WAIT->ERROR when the wait counter equals TIMEOUT_CYCLES-1 and MemReadyM_i is still 0.
- ERROR is terminal until rst.
REQ-023 Wait counter (8 bits for the default) SHALL clear on entry to WAIT and increment each WAIT cycle in which MemReadyM_i==0.
REQ-024 MemTimeout_o SHALL be registered: 1 exactly while state==ERROR.
REQ-025 StallCycles_o SHALL increment by one in each cycle where StallF_o==1, and SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-026 While rst is high, state SHALL be RUN, the wait counter 0, StallCycles_o 0 and MemTimeout_o 0. These take effect immediately and asynchronously.
REQ-027 Assertion of rst during WAIT or ERROR SHALL return the block to RUN with all stall and flush outputs deasserted in the next cycle, given quiescent inputs.

Structure
REQ-028 Package hazard_pkg SHALL hold:
- the state enum (RUN, WAIT, ERROR);
- forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
- RESULTSRC_LOAD=2'b01.
REQ-029 One sub-module, sat_counter (a parameterised-width saturating counter with enable and async reset), SHALL implement StallCycles_o. All other logic is flat.

Verification
REQ-030 Forwarding: RdM=RdW=Rs1E=5, both RegWrite=1 -> ForwardAE=10. Repeat with RdM=0 -> ForwardAE=01.
REQ-031 Load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for exactly one cycle, and StallCycles increments by 1.
REQ-032 Memory wait: MemAccessM=1, MemReadyM=0 for 4 cycles then 1 -> StallF/D/E/M and FlushW high for 4 cycles, FSM returns to RUN, StallCycles=4.
REQ-033 Branch during wait: PCSrcE=1 throughout a 3-cycle wait -> FlushD/FlushE held 0 for the 3 wait cycles, then high in the release cycle.
REQ-034 Timeout: MemReadyM held 0 with TIMEOUT_CYCLES=8 -> MemTimeout_o rises after the 8th wait cycle, all stalls stay high, and asserting rst clears everything.
